// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a valid/ready input FIFO.
// Optional break generation (brk_req port, BREAK/GUARD states) when UART_TX_BREAK_EN is defined.
module uart_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          s_valid,
    input  logic [DATA_W-1:0]             s_data,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef UART_TX_BREAK_EN
    ,
    input  logic                          brk_req
`endif
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned BIT_W   = $clog2(DATA_W);
    localparam logic        PAR_ODD = 1'(PARITY == 2);
    localparam logic        HAS_PAR = 1'(PARITY != 0);

`ifdef UART_TX_BREAK_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK, ST_GUARD
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;
`endif

    // Input FIFO storage and pointers
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic [LVL_W-1:0]  count_next;
    logic              push;
    logic              pop;
    logic              fifo_nonempty;
    logic [DATA_W-1:0] fifo_rd;

    // Serializer state
    state_t            state;
    state_t            state_n;
    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  cnt_n;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_n;
    logic [DIV_W-1:0]  div_clamp;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_n;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  bit_n;
    logic              par_q;
    logic              par_n;
    logic              stop_idx;
    logic              stop_n;
    logic              tx_n;
    logic              busy_n;
    logic              bit_end;
    logic              start_frame;

    assign push          = s_valid && s_ready;
    assign fifo_nonempty = (count != '0);
    assign fifo_rd       = mem[rd_ptr];
    assign count_next    = count + LVL_W'(push) - LVL_W'(pop);
    assign fifo_level    = count;

    // A divisor below 2 would leave no room to count a bit period
    assign div_clamp = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
    assign bit_end   = (cnt == div_q - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            s_ready <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_next;
            s_ready <= (count_next != LVL_W'(FIFO_DEPTH));
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            div_q    <= DIV_W'(2);
            shreg    <= '0;
            bit_idx  <= '0;
            par_q    <= 1'b0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            div_q    <= div_n;
            shreg    <= shreg_n;
            bit_idx  <= bit_n;
            par_q    <= par_n;
            stop_idx <= stop_n;
            tx       <= tx_n;
            busy     <= busy_n;
        end
    end

    // Next-state logic; tx_n is the line level for the cycle after this edge
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + DIV_W'(1);
        div_n       = div_q;
        shreg_n     = shreg;
        bit_n       = bit_idx;
        par_n       = par_q;
        stop_n      = stop_idx;
        tx_n        = tx;
        pop         = 1'b0;
        start_frame = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                tx_n  = 1'b1;
`ifdef UART_TX_BREAK_EN
                if (brk_req) begin
                    state_n = ST_BREAK;
                    tx_n    = 1'b0;
                    div_n   = div_clamp;
                end else if (fifo_nonempty) begin
                    start_frame = 1'b1;
                end
`else
                if (fifo_nonempty) begin
                    start_frame = 1'b1;
                end
`endif
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_DATA;
                    bit_n   = '0;
                    tx_n    = shreg[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == BIT_W'(DATA_W - 1)) begin
                        if (HAS_PAR) begin
                            state_n = ST_PARITY;
                            tx_n    = par_q;
                        end else begin
                            state_n = ST_STOP;
                            stop_n  = 1'b0;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_idx + BIT_W'(1);
                        shreg_n = {1'b0, shreg[DATA_W-1:1]};
                        tx_n    = shreg[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = ST_STOP;
                    stop_n  = 1'b0;
                    tx_n    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (stop_idx == 1'(STOP_BITS - 1)) begin
                        // Chain straight into the next start bit when data is waiting
                        if (fifo_nonempty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        stop_n = 1'b1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
                cnt_n = '0;
                tx_n  = 1'b0;
                if (!brk_req) begin
                    state_n = ST_GUARD;
                    tx_n    = 1'b1;
                end
            end
            ST_GUARD: begin
                tx_n = 1'b1;
                if (bit_end) begin
                    state_n = ST_IDLE;
                end
            end
`endif
            default: begin
                state_n = ST_IDLE;
                tx_n    = 1'b1;
            end
        endcase

        // Pop and latch the character, divisor and parity for a new frame
        if (start_frame) begin
            pop     = 1'b1;
            state_n = ST_START;
            cnt_n   = '0;
            div_n   = div_clamp;
            shreg_n = fifo_rd;
            par_n   = (^fifo_rd) ^ PAR_ODD;
            tx_n    = 1'b0;
        end

        busy_n = (state_n != ST_IDLE) || (count_next != '0);
    end

endmodule
